// File: rtl/polyeta_unpack_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : polyeta_unpack_stream_pkg
// Brief   : Shared constants for the eta-polynomial pack/unpack datapath:
//           polynomial geometry, eta bound, coefficient width and the FSM
//           state encodings used by the pack and unpack blocks.
// Revision: 1.0 - initial release
// ============================================================================
package polyeta_unpack_stream_pkg;

  // Polynomial geometry
  localparam int N              = 256;
  localparam int ETA            = 4;
  localparam int COEFF_W        = 32;
  localparam int NIBBLE_W       = 4;
  localparam int BYTES_PER_POLY = N / 2;

  // FSM state encodings, shared with polyeta_pack users
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/polyeta_nibble_decode.sv
`default_nettype none
// ============================================================================
// Module  : polyeta_nibble_decode
// Brief   : Combinational decode of one packed nibble t into the signed
//           coefficient ETA - t (sign-extended), plus a flag for t > 2*ETA.
// Revision: 1.0 - initial release
// ============================================================================
module polyeta_nibble_decode
  import polyeta_unpack_stream_pkg::*;
(
  input  logic [NIBBLE_W-1:0] t_i,
  output logic [COEFF_W-1:0]  coeff_o,
  output logic                range_err_o
);

  // One extra bit holds the full range ETA-15 .. ETA without overflow
  localparam logic [NIBBLE_W:0] c_eta     = (NIBBLE_W+1)'(ETA);
  localparam logic [NIBBLE_W:0] c_eta_max = (NIBBLE_W+1)'(2 * ETA);

  logic [NIBBLE_W:0] w_t_ext;
  logic [NIBBLE_W:0] w_diff;

  assign w_t_ext = {1'b0, t_i};
  assign w_diff  = c_eta - w_t_ext;

  // Sign-extend the narrow two's-complement difference to the output width
  assign coeff_o     = {{(COEFF_W-NIBBLE_W-1){w_diff[NIBBLE_W]}}, w_diff};
  assign range_err_o = (w_t_ext > c_eta_max);

endmodule
`default_nettype wire

// File: rtl/polyeta_unpack_stream.sv
`default_nettype none
// ============================================================================
// Module  : polyeta_unpack_stream
// Brief   : Streams in a 128-byte packed eta polynomial one byte per beat,
//           decodes each byte into two coefficients, buffers all 256 and
//           presents the complete polynomial with a valid/ready handoff.
// Revision: 1.0 - initial release
// ============================================================================
module polyeta_unpack_stream
  import polyeta_unpack_stream_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [N*COEFF_W-1:0] a_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err,
  output logic                 busy
);

  localparam int                CNT_W     = $clog2(BYTES_PER_POLY);
  localparam logic [CNT_W-1:0]  c_last_ix = CNT_W'(BYTES_PER_POLY - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic                err_q, err_d;
  logic                s_ready_q, s_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [COEFF_W-1:0]  coeff_q [N];

  logic [COEFF_W-1:0]  w_coeff_lo;
  logic [COEFF_W-1:0]  w_coeff_hi;
  logic                w_rerr_lo;
  logic                w_rerr_hi;
  logic                w_beat;

  // s_ready is only high in LOAD; a beat coincident with start is dropped
  assign w_beat = s_valid & s_ready_q & ~start;

  polyeta_nibble_decode u_dec_lo (
    .t_i         (s_data[3:0]),
    .coeff_o     (w_coeff_lo),
    .range_err_o (w_rerr_lo)
  );

  polyeta_nibble_decode u_dec_hi (
    .t_i         (s_data[7:4]),
    .coeff_o     (w_coeff_hi),
    .range_err_o (w_rerr_hi)
  );

  // Next-state logic: start overrides every state, including a DONE handoff
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    err_d       = err_q;
    s_ready_d   = s_ready_q;
    out_valid_d = out_valid_q;
    if (start) begin
      state_d     = LOAD;
      byte_cnt_d  = '0;
      err_d       = 1'b0;
      s_ready_d   = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          s_ready_d   = 1'b0;
          out_valid_d = 1'b0;
        end
        LOAD: begin
          if (w_beat) begin
            err_d = err_q | w_rerr_lo | w_rerr_hi;
            if (byte_cnt_q == c_last_ix) begin
              state_d     = DONE;
              s_ready_d   = 1'b0;
              out_valid_d = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          s_ready_d   = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      err_q       <= 1'b0;
      s_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      err_q       <= err_d;
      s_ready_q   <= s_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Coefficient buffer: each beat writes the even/odd pair for its byte index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        coeff_q[i] <= '0;
      end
    end else if (w_beat) begin
      coeff_q[{byte_cnt_q, 1'b0}] <= w_coeff_lo;
      coeff_q[{byte_cnt_q, 1'b1}] <= w_coeff_hi;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_out
      assign a_out[gi*COEFF_W +: COEFF_W] = coeff_q[gi];
    end
  endgenerate

  assign s_ready   = s_ready_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
